decoder_skid: RTL and testbench

//   RV32I instruction decode stage with valid/ready handshakes on both sides and a
//   2-entry skid buffer, so fetch and execute can each stall without combinational

---
 rtl/decoder_skid.sv | 333 +++++++++++++++++++++++++++++++++
 tb/tb_decoder_skid.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_skid.sv
// RV32I decode stage: registered decode results behind a 2-entry (output reg + skid) buffer.
// Latency 1 cycle from accept to ds_o_valid; 1 beat/cycle while ds_i_ready stays high.
// Backpressure: ds_o_ready = !skid_valid, a registered signal with no combinational path from ds_i_ready.
module decoder_skid #(
  parameter int DWIDTH   = 32,
  parameter int IWIDTH   = 32,
  parameter int AWIDTH   = 5,
  parameter int PC_WIDTH = 32,
  parameter int EN_M     = 0,
  parameter int EN_ZICSR = 0
) (
  input  logic                ds_clk,
  input  logic                ds_rst,
  input  logic                ds_i_valid,
  output logic                ds_o_ready,
  input  logic [IWIDTH-1:0]   ds_i_instr,
  input  logic [PC_WIDTH-1:0] ds_i_pc,
  output logic                ds_o_valid,
  input  logic                ds_i_ready,
  input  logic                ds_i_flush,
  output logic [PC_WIDTH-1:0] ds_o_pc,
  output logic [AWIDTH-1:0]   ds_o_addr_rs1,
  output logic [AWIDTH-1:0]   ds_o_addr_rs2,
  output logic [AWIDTH-1:0]   ds_o_addr_rd,
  output logic [2:0]          ds_o_funct3,
  output logic [DWIDTH-1:0]   ds_o_imm,
  output logic [13:0]         ds_o_alu,
  output logic [10:0]         ds_o_opcode,
  output logic [3:0]          ds_o_muldiv,
  output logic [3:0]          ds_o_exception
);

  // One-hot bit positions shared with execute.
  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLT  = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_XOR  = 4;
  localparam int ALU_OR   = 5;
  localparam int ALU_AND  = 6;
  localparam int ALU_SLL  = 7;
  localparam int ALU_SRL  = 8;
  localparam int ALU_SRA  = 9;
  localparam int ALU_EQ   = 10;
  localparam int ALU_NEQ  = 11;
  localparam int ALU_GE   = 12;
  localparam int ALU_GEU  = 13;

  localparam int CLS_RTYPE  = 0;
  localparam int CLS_ITYPE  = 1;
  localparam int CLS_LOAD   = 2;
  localparam int CLS_STORE  = 3;
  localparam int CLS_BRANCH = 4;
  localparam int CLS_JAL    = 5;
  localparam int CLS_JALR   = 6;
  localparam int CLS_LUI    = 7;
  localparam int CLS_AUIPC  = 8;
  localparam int CLS_SYSTEM = 9;
  localparam int CLS_FENCE  = 10;

  localparam int EXC_ILLEGAL = 0;
  localparam int EXC_ECALL   = 1;
  localparam int EXC_EBREAK  = 2;
  localparam int EXC_MRET    = 3;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic [AWIDTH-1:0]   rs1;
    logic [AWIDTH-1:0]   rs2;
    logic [AWIDTH-1:0]   rd;
    logic [2:0]          funct3;
    logic [DWIDTH-1:0]   imm;
    logic [13:0]         alu;
    logic [10:0]         opcode;
    logic [3:0]          muldiv;
    logic [3:0]          exc;
  } beat_t;

  function automatic logic [13:0] alu_arith(input logic [2:0] fn3, input logic alt_add,
                                            input logic alt_shift);
    logic [13:0] oh;
    oh = '0;
    case (fn3)
      3'b000:  oh[alt_add ? ALU_SUB : ALU_ADD] = 1'b1;
      3'b001:  oh[ALU_SLL] = 1'b1;
      3'b010:  oh[ALU_SLT] = 1'b1;
      3'b011:  oh[ALU_SLTU] = 1'b1;
      3'b100:  oh[ALU_XOR] = 1'b1;
      3'b101:  oh[alt_shift ? ALU_SRA : ALU_SRL] = 1'b1;
      3'b110:  oh[ALU_OR] = 1'b1;
      default: oh[ALU_AND] = 1'b1;
    endcase
    return oh;
  endfunction

  logic [31:0] ins;
  logic [6:0]  opc;
  logic [6:0]  f7;
  logic [2:0]  f3;
  logic [4:0]  rs1_w;
  logic [4:0]  rs2_w;
  logic [4:0]  rd_w;
  logic [2:0]  f3_w;
  logic [31:0] imm32;
  logic [13:0] alu_oh;
  logic [10:0] cls_oh;
  logic [3:0]  md;
  logic        ill;
  logic        is_ecall;
  logic        is_ebreak;
  logic        is_mret;
  beat_t       dec_beat;

  assign ins = ds_i_instr[31:0];
  assign opc = ins[6:0];
  assign f7  = ins[31:25];
  assign f3  = ins[14:12];

  always_comb begin
    rs1_w     = '0;
    rs2_w     = '0;
    rd_w      = '0;
    f3_w      = '0;
    imm32     = '0;
    alu_oh    = '0;
    alu_oh[ALU_ADD] = 1'b1;
    cls_oh    = '0;
    md        = '0;
    ill       = 1'b0;
    is_ecall  = 1'b0;
    is_ebreak = 1'b0;
    is_mret   = 1'b0;
    case (opc)
      OPC_RTYPE: begin
        cls_oh[CLS_RTYPE] = 1'b1;
        rs1_w = ins[19:15];
        rs2_w = ins[24:20];
        rd_w  = ins[11:7];
        f3_w  = f3;
        // M ops keep the default ADD selection; execute steers them by ds_o_muldiv.
        if (f7 == 7'b0000001) begin
          if (EN_M != 0) md = {1'b1, f3};
          else ill = 1'b1;
        end else if (f7 == 7'b0000000 ||
                     (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))) begin
          alu_oh = alu_arith(f3, ins[30], ins[30]);
        end else begin
          ill = 1'b1;
        end
      end
      OPC_ITYPE: begin
        cls_oh[CLS_ITYPE] = 1'b1;
        rs1_w  = ins[19:15];
        rd_w   = ins[11:7];
        f3_w   = f3;
        imm32  = {{20{ins[31]}}, ins[31:20]};
        alu_oh = alu_arith(f3, 1'b0, ins[30]);
        if (f3 == 3'b001 && f7 != 7'b0000000) ill = 1'b1;
        if (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000) ill = 1'b1;
      end
      OPC_LOAD: begin
        cls_oh[CLS_LOAD] = 1'b1;
        rs1_w = ins[19:15];
        rd_w  = ins[11:7];
        f3_w  = f3;
        imm32 = {{20{ins[31]}}, ins[31:20]};
        if (f3 == 3'b011 || f3[2:1] == 2'b11) ill = 1'b1;
      end
      OPC_STORE: begin
        cls_oh[CLS_STORE] = 1'b1;
        rs1_w = ins[19:15];
        rs2_w = ins[24:20];
        f3_w  = f3;
        imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        if (f3 > 3'b010) ill = 1'b1;
      end
      OPC_BRANCH: begin
        cls_oh[CLS_BRANCH] = 1'b1;
        rs1_w  = ins[19:15];
        rs2_w  = ins[24:20];
        f3_w   = f3;
        imm32  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        alu_oh = '0;
        case (f3)
          3'b000:  alu_oh[ALU_EQ] = 1'b1;
          3'b001:  alu_oh[ALU_NEQ] = 1'b1;
          3'b100:  alu_oh[ALU_SLT] = 1'b1;
          3'b101:  alu_oh[ALU_GE] = 1'b1;
          3'b110:  alu_oh[ALU_SLTU] = 1'b1;
          3'b111:  alu_oh[ALU_GEU] = 1'b1;
          default: ill = 1'b1;
        endcase
      end
      OPC_JAL: begin
        cls_oh[CLS_JAL] = 1'b1;
        rd_w  = ins[11:7];
        imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      OPC_JALR: begin
        cls_oh[CLS_JALR] = 1'b1;
        rs1_w = ins[19:15];
        rd_w  = ins[11:7];
        f3_w  = f3;
        imm32 = {{20{ins[31]}}, ins[31:20]};
        if (f3 != 3'b000) ill = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        cls_oh[(opc == OPC_LUI) ? CLS_LUI : CLS_AUIPC] = 1'b1;
        rd_w  = ins[11:7];
        imm32 = {ins[31:12], 12'b0};
      end
      OPC_SYSTEM: begin
        cls_oh[CLS_SYSTEM] = 1'b1;
        rs1_w = ins[19:15];
        rd_w  = ins[11:7];
        f3_w  = f3;
        imm32 = {20'b0, ins[31:20]};
        if (f3 == 3'b000) begin
          case (ins[31:20])
            12'h000: is_ecall  = 1'b1;
            12'h001: is_ebreak = 1'b1;
            12'h302: is_mret   = 1'b1;
            default: ill       = 1'b1;
          endcase
        end else if (f3 == 3'b100 || EN_ZICSR == 0) begin
          ill = 1'b1;
        end
      end
      OPC_FENCE: begin
        cls_oh[CLS_FENCE] = 1'b1;
        rs1_w = ins[19:15];
        rd_w  = ins[11:7];
        f3_w  = f3;
        imm32 = {20'b0, ins[31:20]};
      end
      default: ill = 1'b1;
    endcase
    if (ds_i_instr == '0 || ds_i_instr == '1) ill = 1'b1;
  end

  always_comb begin
    dec_beat        = '0;
    dec_beat.pc     = ds_i_pc;
    dec_beat.rs1    = AWIDTH'(rs1_w);
    dec_beat.rs2    = AWIDTH'(rs2_w);
    dec_beat.rd     = AWIDTH'(rd_w);
    dec_beat.funct3 = f3_w;
    dec_beat.imm    = DWIDTH'($signed(imm32));
    // Illegal beats still travel downstream, but carry no operation for execute to start.
    if (ill) begin
      dec_beat.exc[EXC_ILLEGAL] = 1'b1;
    end else begin
      dec_beat.alu            = alu_oh;
      dec_beat.opcode         = cls_oh;
      dec_beat.muldiv         = md;
      dec_beat.exc[EXC_ECALL]  = is_ecall;
      dec_beat.exc[EXC_EBREAK] = is_ebreak;
      dec_beat.exc[EXC_MRET]   = is_mret;
    end
  end

  beat_t out_q, out_d, skid_q, skid_d;
  logic  out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
  logic  accept, fire;

  assign ds_o_ready = !skid_vld_q;
  assign accept     = ds_i_valid && !skid_vld_q;
  assign fire       = out_vld_q && ds_i_ready;

  always_comb begin
    out_d      = out_q;
    skid_d     = skid_q;
    out_vld_d  = out_vld_q;
    skid_vld_d = skid_vld_q;
    if (ds_i_flush) begin
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!out_vld_q || fire) begin
      // Skid is older than anything arriving now, so it refills the output slot first.
      if (skid_vld_q) begin
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_vld_d = accept;
        if (accept) skid_d = dec_beat;
      end else begin
        out_vld_d = accept;
        if (accept) out_d = dec_beat;
      end
    end else if (accept) begin
      skid_d     = dec_beat;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge ds_clk or negedge ds_rst) begin
    if (!ds_rst) begin
      out_q      <= '0;
      skid_q     <= '0;
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      skid_q     <= skid_d;
      out_vld_q  <= out_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  assign ds_o_valid     = out_vld_q;
  assign ds_o_pc        = out_q.pc;
  assign ds_o_addr_rs1  = out_q.rs1;
  assign ds_o_addr_rs2  = out_q.rs2;
  assign ds_o_addr_rd   = out_q.rd;
  assign ds_o_funct3    = out_q.funct3;
  assign ds_o_imm       = out_q.imm;
  assign ds_o_alu       = out_q.alu;
  assign ds_o_opcode    = out_q.opcode;
  assign ds_o_muldiv    = out_q.muldiv;
  assign ds_o_exception = out_q.exc;

endmodule

// File: tb/tb_decoder_skid.sv
// Bench for decoder_skid: two instances (base ISA only, and with M + Zicsr) share one stimulus
// stream and are checked every cycle against a queue-based reference of the in-flight beats.
module tb_decoder_skid;

  logic        ds_clk = 1'b0;
  logic        ds_rst;
  logic        i_valid;
  logic        i_ready;
  logic        i_flush;
  logic [31:0] i_instr;
  logic [31:0] i_pc;
  wire         o_rdy0, o_vld0, o_rdy1, o_vld1;
  // {pc, rs1, rs2, rd, funct3, imm, alu, opcode, muldiv, exception}
  wire [114:0] act0, act1;

  int tests = 0;
  int fails = 0;

  always #5 ds_clk = ~ds_clk;

  decoder_skid #(.EN_M(0), .EN_ZICSR(0)) u0 (
    .ds_clk(ds_clk), .ds_rst(ds_rst), .ds_i_valid(i_valid), .ds_o_ready(o_rdy0),
    .ds_i_instr(i_instr), .ds_i_pc(i_pc), .ds_o_valid(o_vld0), .ds_i_ready(i_ready),
    .ds_i_flush(i_flush), .ds_o_pc(act0[114:83]), .ds_o_addr_rs1(act0[82:78]),
    .ds_o_addr_rs2(act0[77:73]), .ds_o_addr_rd(act0[72:68]), .ds_o_funct3(act0[67:65]),
    .ds_o_imm(act0[64:33]), .ds_o_alu(act0[32:19]), .ds_o_opcode(act0[18:8]),
    .ds_o_muldiv(act0[7:4]), .ds_o_exception(act0[3:0]));

  decoder_skid #(.EN_M(1), .EN_ZICSR(1)) u1 (
    .ds_clk(ds_clk), .ds_rst(ds_rst), .ds_i_valid(i_valid), .ds_o_ready(o_rdy1),
    .ds_i_instr(i_instr), .ds_i_pc(i_pc), .ds_o_valid(o_vld1), .ds_i_ready(i_ready),
    .ds_i_flush(i_flush), .ds_o_pc(act1[114:83]), .ds_o_addr_rs1(act1[82:78]),
    .ds_o_addr_rs2(act1[77:73]), .ds_o_addr_rd(act1[72:68]), .ds_o_funct3(act1[67:65]),
    .ds_o_imm(act1[64:33]), .ds_o_alu(act1[32:19]), .ds_o_opcode(act1[18:8]),
    .ds_o_muldiv(act1[7:4]), .ds_o_exception(act1[3:0]));

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode from the ISA tables: format decides which fields exist, class and
  // funct fields decide ALU/legality. Returns {rs1,rs2,rd,funct3,imm,alu,opcode,muldiv,exc}.
  function automatic logic [82:0] ref_dec(input logic [31:0] ins, input bit en_m, input bit en_csr);
    int fmt, cls, alu;
    int arith[8];
    int brn[8];
    bit ill, ec, eb, mr;
    logic [6:0] f7;
    logic [2:0] f3, f3o;
    logic [3:0] md, exc_v;
    logic [4:0] rs1, rs2, rd;
    logic [31:0] imm;
    logic [13:0] alu_v;
    logic [10:0] opc_v;
    arith = '{0, 7, 2, 3, 4, 8, 5, 6};
    brn   = '{10, 11, 0, 0, 2, 12, 3, 13};
    f7 = ins[31:25]; f3 = ins[14:12];
    ill = 0; ec = 0; eb = 0; mr = 0; md = 4'd0; alu = 0;
    // fmt: 0 none, 1 R, 2 I, 3 S, 4 B, 5 U, 6 J, 7 zero-extended I
    case (ins[6:0])
      7'h33:   begin cls = 0;  fmt = 1; end
      7'h13:   begin cls = 1;  fmt = 2; end
      7'h03:   begin cls = 2;  fmt = 2; end
      7'h23:   begin cls = 3;  fmt = 3; end
      7'h63:   begin cls = 4;  fmt = 4; end
      7'h6F:   begin cls = 5;  fmt = 6; end
      7'h67:   begin cls = 6;  fmt = 2; end
      7'h37:   begin cls = 7;  fmt = 5; end
      7'h17:   begin cls = 8;  fmt = 5; end
      7'h73:   begin cls = 9;  fmt = 7; end
      7'h0F:   begin cls = 10; fmt = 7; end
      default: begin cls = 0;  fmt = 0; ill = 1; end
    endcase
    if (ins == 32'h0 || ins == 32'hFFFF_FFFF) ill = 1;
    if (fmt != 0) begin
      case (cls)
        0: if (f7 == 7'h01) begin
             if (en_m) md = {1'b1, f3}; else ill = 1;
           end else if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 0 || f3 == 5))) begin
             alu = arith[f3];
             if (f7 == 7'h20) alu = (f3 == 0) ? 1 : 9;
           end else ill = 1;
        1: begin
             alu = arith[f3];
             if (f3 == 5 && ins[30]) alu = 9;
             if (f3 == 1 && f7 != 0) ill = 1;
             if (f3 == 5 && !(f7 == 0 || f7 == 7'h20)) ill = 1;
           end
        2: if (f3 == 3 || f3 == 6 || f3 == 7) ill = 1;
        3: if (f3 > 2) ill = 1;
        4: if (f3 == 2 || f3 == 3) ill = 1; else alu = brn[f3];
        6: if (f3 != 0) ill = 1;
        9: if (f3 == 0) begin
             if (ins[31:20] == 12'h000) ec = 1;
             else if (ins[31:20] == 12'h001) eb = 1;
             else if (ins[31:20] == 12'h302) mr = 1;
             else ill = 1;
           end else if (f3 == 4 || !en_csr) ill = 1;
        default: ;
      endcase
    end
    rs1 = (fmt inside {1, 2, 3, 4, 7}) ? ins[19:15] : 5'd0;
    rs2 = (fmt inside {1, 3, 4}) ? ins[24:20] : 5'd0;
    rd  = (fmt inside {1, 2, 5, 6, 7}) ? ins[11:7] : 5'd0;
    f3o = (fmt inside {1, 2, 3, 4, 7}) ? f3 : 3'd0;
    case (fmt)
      2:       imm = {{20{ins[31]}}, ins[31:20]};
      3:       imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      4:       imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      5:       imm = {ins[31:12], 12'b0};
      6:       imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      7:       imm = {20'b0, ins[31:20]};
      default: imm = 32'd0;
    endcase
    alu_v = ill ? 14'd0 : (14'd1 << alu);
    opc_v = ill ? 11'd0 : (11'd1 << cls);
    exc_v = ill ? 4'b0001 : {mr, eb, ec, 1'b0};
    if (ill) md = 4'd0;
    return {rs1, rs2, rd, f3o, imm, alu_v, opc_v, md, exc_v};
  endfunction

  // In-flight beats in order; head is what the output must show.
  typedef struct packed { logic [31:0] pc; logic [31:0] ins; } ent_t;
  ent_t mq[$];
  bit m_acc, m_fire;

  always @(posedge ds_clk or negedge ds_rst) begin
    if (!ds_rst) begin
      mq.delete();
    end else begin
      m_acc  = i_valid && (mq.size() < 2);
      m_fire = (mq.size() > 0) && i_ready;
      if (i_flush) begin
        mq.delete();
      end else begin
        if (m_fire) void'(mq.pop_front());
        if (m_acc) mq.push_back(ent_t'{pc: i_pc, ins: i_instr});
      end
    end
  end

  always @(negedge ds_clk) begin
    if (ds_rst) begin
      chk("ready_base", 128'(o_rdy0), 128'(mq.size() < 2));
      chk("valid_base", 128'(o_vld0), 128'(mq.size() > 0));
      chk("ready_ext", 128'(o_rdy1), 128'(mq.size() < 2));
      chk("valid_ext", 128'(o_vld1), 128'(mq.size() > 0));
      if (mq.size() > 0) begin
        chk("beat_base", 128'(act0), 128'({mq[0].pc, ref_dec(mq[0].ins, 1'b0, 1'b0)}));
        chk("beat_ext", 128'(act1), 128'({mq[0].pc, ref_dec(mq[0].ins, 1'b1, 1'b1)}));
      end
    end
  end

  task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
    @(negedge ds_clk);
    i_valid = 1'b1; i_instr = ins; i_pc = pc; i_ready = 1'b1; i_flush = 1'b0;
    @(negedge ds_clk);
    i_valid = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_vec_base"}, 128'(act0), 128'd0);
    chk({tag, "_vec_ext"}, 128'(act1), 128'd0);
    chk({tag, "_vld"}, 128'({o_vld0, o_vld1}), 128'd0);
    chk({tag, "_rdy"}, 128'({o_rdy0, o_rdy1}), 128'd3);
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom_range(0, 15);
    case (k)
      0: r[6:0] = 7'h33;  1: r[6:0] = 7'h13;  2: r[6:0] = 7'h03;  3: r[6:0] = 7'h23;
      4: r[6:0] = 7'h63;  5: r[6:0] = 7'h6F;  6: r[6:0] = 7'h67;  7: r[6:0] = 7'h37;
      8: r[6:0] = 7'h17;  9: r[6:0] = 7'h73;  10: r[6:0] = 7'h0F;
      11: r = 32'h0;      12: r = 32'hFFFF_FFFF;
      default: ;
    endcase
    if (k <= 1) begin
      case ($urandom_range(0, 3))
        0: r[31:25] = 7'h00;
        1: r[31:25] = 7'h20;
        2: r[31:25] = 7'h01;
        default: ;
      endcase
    end
    if (k == 9 && $urandom_range(0, 1) == 1) begin
      r[14:12] = 3'b000;
      case ($urandom_range(0, 3))
        0: r[31:20] = 12'h000;
        1: r[31:20] = 12'h001;
        2: r[31:20] = 12'h302;
        default: r[31:20] = 12'h105;
      endcase
    end
    return r;
  endfunction

  initial begin
    ds_rst = 1'b0; i_valid = 1'b0; i_ready = 1'b1; i_flush = 1'b0;
    i_instr = 32'h0; i_pc = 32'h0;
    #12;
    chk_reset_state("reset");
    @(negedge ds_clk);
    ds_rst = 1'b1;

    // add x3,x1,x2
    issue(32'h002081B3, 32'h1000);
    chk("add_vld", 128'(o_vld0), 128'd1);
    chk("add_regs", 128'(act0[82:68]), 128'({5'd1, 5'd2, 5'd3}));
    chk("add_alu", 128'(act0[32:19]), 128'(14'h0001));
    chk("add_opc", 128'(act0[18:8]), 128'(11'h001));
    chk("add_exc", 128'(act0[3:0]), 128'd0);
    chk("add_pc", 128'(act0[114:83]), 128'h1000);

    // mul x3,x1,x2 with and without M
    issue(32'h022081B3, 32'h1004);
    chk("mul_base_exc", 128'(act0[3:0]), 128'(4'b0001));
    chk("mul_base_alu", 128'(act0[32:19]), 128'd0);
    chk("mul_base_md", 128'(act0[7:4]), 128'd0);
    chk("mul_ext_md", 128'(act1[7:4]), 128'(4'b1000));
    chk("mul_ext_exc", 128'(act1[3:0]), 128'd0);

    issue(32'h00000073, 32'h1008);
    chk("ecall_exc", 128'(act0[3:0]), 128'(4'b0010));
    issue(32'h30200073, 32'h100C);
    chk("mret_exc", 128'(act0[3:0]), 128'(4'b1000));
    issue(32'h10500073, 32'h1010);
    chk("wfi_exc", 128'(act0[3:0]), 128'(4'b0001));
    issue(32'h40209093, 32'h1014);
    chk("slli_f7_exc", 128'(act0[3:0]), 128'(4'b0001));
    chk("slli_f7_opc", 128'(act0[18:8]), 128'd0);

    // beq x1,x2,-4
    issue(32'hFE208EE3, 32'h1018);
    chk("beq_imm", 128'(act0[64:33]), 128'(32'hFFFF_FFFC));
    chk("beq_alu", 128'(act0[32:19]), 128'(14'h0400));
    chk("beq_opc", 128'(act0[18:8]), 128'(11'h010));
    chk("beq_rd", 128'(act0[72:68]), 128'd0);

    // lui x1,0x12345
    issue(32'h123450B7, 32'h101C);
    chk("lui_imm", 128'(act0[64:33]), 128'(32'h1234_5000));
    chk("lui_rd_rs1", 128'(act0[82:68]), 128'({5'd0, 5'd0, 5'd1}));
    chk("lui_opc", 128'(act0[18:8]), 128'(11'h080));

    // Stall downstream, offer three back-to-back beats
    @(negedge ds_clk);
    i_ready = 1'b0; i_valid = 1'b1; i_instr = 32'h002081B3; i_pc = 32'h2000;
    @(negedge ds_clk);
    i_pc = 32'h2004;
    @(negedge ds_clk);
    chk("bp_third_rdy", 128'(o_rdy0), 128'd0);
    i_pc = 32'h2008;
    @(negedge ds_clk);
    i_valid = 1'b0; i_ready = 1'b1;
    chk("bp_first_pc", 128'({o_vld0, act0[114:83]}), 128'({1'b1, 32'h2000}));
    @(negedge ds_clk);
    chk("bp_second_pc", 128'({o_vld0, act0[114:83]}), 128'({1'b1, 32'h2004}));
    @(negedge ds_clk);
    chk("bp_drained", 128'(o_vld0), 128'd0);

    // Fill both slots, then flush while offering a beat
    @(negedge ds_clk);
    i_ready = 1'b0; i_valid = 1'b1; i_pc = 32'h3000;
    @(negedge ds_clk);
    i_pc = 32'h3004;
    @(negedge ds_clk);
    chk("fl_full", 128'({o_vld0, o_rdy0}), 128'(2'b10));
    i_flush = 1'b1; i_pc = 32'h3008;
    @(negedge ds_clk);
    chk("fl_after", 128'({o_vld0, o_rdy0}), 128'(2'b01));
    i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    @(negedge ds_clk);
    chk("fl_no_ghost", 128'(o_vld0), 128'd0);

    // Async reset between edges with beats in flight
    @(negedge ds_clk);
    i_ready = 1'b0; i_valid = 1'b1; i_instr = 32'hFE208EE3; i_pc = 32'h4000;
    @(negedge ds_clk);
    i_pc = 32'h4004;
    @(negedge ds_clk);
    i_valid = 1'b0;
    @(posedge ds_clk);
    #2 ds_rst = 1'b0;
    #1 chk_reset_state("midrst");
    @(negedge ds_clk);
    ds_rst = 1'b1;
    issue(32'h002081B3, 32'h5000);
    chk("post_rst_regs", 128'({o_vld0, act0[82:68]}), 128'({1'b1, 5'd1, 5'd2, 5'd3}));
    chk("post_rst_pc", 128'(act0[114:83]), 128'h5000);

    // Random traffic with random stalls and occasional flushes
    for (int i = 0; i < 3000; i++) begin
      @(negedge ds_clk);
      i_valid = ($urandom_range(0, 9) < 7);
      i_instr = rnd_instr();
      i_pc    = 32'h8000 + 32'(i) * 4;
      i_ready = ($urandom_range(0, 9) < 7);
      i_flush = ($urandom_range(0, 49) == 0);
    end
    @(negedge ds_clk);
    i_valid = 1'b0; i_ready = 1'b1; i_flush = 1'b0;
    repeat (4) @(negedge ds_clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
